// File: rtl/mem_stage_dm.sv
// mem_stage_dm: MEM-stage data memory and load/store unit of the 5-stage MIPS
// pipeline. Holds DM_WORDS 32-bit words and performs aligned word/half/byte
// stores on the clock edge. Load data comes back combinationally, sign- or
// zero-extended. Misaligned or out-of-range accesses raise a sticky AddrErr,
// and the block counts committed stores.
// Optional feature: define DM_TRACE_EN to print a trace line for every store.
module mem_stage_dm #(
  parameter int DM_WORDS = 3072,
  parameter int ADDR_W   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_MEM,
  input  logic [31:0] Pc4_MEM,
  input  logic [31:0] ALUout_MEM,
  input  logic [31:0] WriteData_MEM,
  input  logic [4:0]  WriteReg_MEM,
  output logic [31:0] ReadData_MEM,
  output logic        LoadValid_MEM,
  output logic [4:0]  WriteReg_out,
  output logic        AddrErr,
  output logic [31:0] StoreCount
);

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } accessSize_t;

  localparam logic [5:0]  OP_LW  = 6'b100011;
  localparam logic [5:0]  OP_LH  = 6'b100001;
  localparam logic [5:0]  OP_LHU = 6'b100101;
  localparam logic [5:0]  OP_LB  = 6'b100000;
  localparam logic [5:0]  OP_LBU = 6'b100100;
  localparam logic [5:0]  OP_SW  = 6'b101011;
  localparam logic [5:0]  OP_SH  = 6'b101001;
  localparam logic [5:0]  OP_SB  = 6'b101000;
  localparam logic [31:0] LP_BYTE_LIMIT = 32'(DM_WORDS * 4);

  logic [31:0]       r_mem [DM_WORDS];
  logic              r_addrErr;
  logic [31:0]       r_storeCount;

  logic              w_isLoad;
  logic              w_isStore;
  logic              w_signExt;
  accessSize_t       w_size;
  logic [1:0]        w_offset;
  logic [ADDR_W-1:0] w_wordIdx;
  logic              w_inRange;
  logic              w_misaligned;
  logic              w_fault;
  logic              w_storeCommit;
  logic [31:0]       w_rdWord;
  logic [31:0]       w_mergedWord;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_loadData;
  logic              w_unused;

  // Only the opcode field selects the operation; the rest of the word
  // (and the PC, outside of tracing) is intentionally ignored.
  assign w_unused = ^{Instr_MEM[25:0], Pc4_MEM};

  assign w_offset  = ALUout_MEM[1:0];
  assign w_wordIdx = ALUout_MEM[ADDR_W+1:2];
  // The full 32-bit address is range-checked, so high bits never alias.
  assign w_inRange = (ALUout_MEM < LP_BYTE_LIMIT);

  // Decode the opcode into load/store, access size and extension type.
  always_comb begin
    w_isLoad  = 1'b0;
    w_isStore = 1'b0;
    w_signExt = 1'b0;
    w_size    = SZ_WORD;
    unique case (Instr_MEM[31:26])
      OP_LW:  begin w_isLoad = 1'b1;  w_size = SZ_WORD; end
      OP_LH:  begin w_isLoad = 1'b1;  w_size = SZ_HALF; w_signExt = 1'b1; end
      OP_LHU: begin w_isLoad = 1'b1;  w_size = SZ_HALF; end
      OP_LB:  begin w_isLoad = 1'b1;  w_size = SZ_BYTE; w_signExt = 1'b1; end
      OP_LBU: begin w_isLoad = 1'b1;  w_size = SZ_BYTE; end
      OP_SW:  begin w_isStore = 1'b1; w_size = SZ_WORD; end
      OP_SH:  begin w_isStore = 1'b1; w_size = SZ_HALF; end
      OP_SB:  begin w_isStore = 1'b1; w_size = SZ_BYTE; end
      default: ;
    endcase
  end

  // A fault is any misaligned or out-of-range memory access.
  always_comb begin
    w_misaligned = 1'b0;
    unique case (w_size)
      SZ_WORD: w_misaligned = (w_offset != 2'b00);
      SZ_HALF: w_misaligned = w_offset[0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_fault       = (w_isLoad | w_isStore) & (w_misaligned | ~w_inRange);
  assign w_storeCommit = w_isStore & ~w_fault & ~reset;

  // An out-of-range index never reaches the array.
  assign w_rdWord = w_inRange ? r_mem[w_wordIdx] : 32'h0;

  // Merge the store data into the current word; untouched lanes keep
  // their old contents.
  always_comb begin
    w_mergedWord = w_rdWord;
    unique case (w_size)
      SZ_WORD: w_mergedWord = WriteData_MEM;
      SZ_HALF: begin
        if (w_offset[1]) w_mergedWord[31:16] = WriteData_MEM[15:0];
        else             w_mergedWord[15:0]  = WriteData_MEM[15:0];
      end
      default: begin
        unique case (w_offset)
          2'd0: w_mergedWord[7:0]   = WriteData_MEM[7:0];
          2'd1: w_mergedWord[15:8]  = WriteData_MEM[7:0];
          2'd2: w_mergedWord[23:16] = WriteData_MEM[7:0];
          default: w_mergedWord[31:24] = WriteData_MEM[7:0];
        endcase
      end
    endcase
  end

  // Select the addressed byte/half and extend it to 32 bits.
  always_comb begin
    unique case (w_offset)
      2'd0: w_byte = w_rdWord[7:0];
      2'd1: w_byte = w_rdWord[15:8];
      2'd2: w_byte = w_rdWord[23:16];
      default: w_byte = w_rdWord[31:24];
    endcase
    w_half = w_offset[1] ? w_rdWord[31:16] : w_rdWord[15:0];
    unique case (w_size)
      SZ_WORD: w_loadData = w_rdWord;
      SZ_HALF: w_loadData = {{16{w_signExt & w_half[15]}}, w_half};
      default: w_loadData = {{24{w_signExt & w_byte[7]}}, w_byte};
    endcase
  end

  assign LoadValid_MEM = w_isLoad & ~w_fault;
  assign ReadData_MEM  = LoadValid_MEM ? w_loadData : 32'h0;
  assign WriteReg_out  = LoadValid_MEM ? WriteReg_MEM : 5'd0;
  assign AddrErr       = r_addrErr;
  assign StoreCount    = r_storeCount;

  // Memory array: cleared on reset (discarding any store in that cycle),
  // otherwise takes the merged word when a store commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= 32'h0;
    end else if (w_storeCommit) begin
      r_mem[w_wordIdx] <= w_mergedWord;
    end
  end

  // Sticky address-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)        r_addrErr <= 1'b0;
    else if (w_fault) r_addrErr <= 1'b1;
  end

  // Committed-store counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset)              r_storeCount <= 32'h0;
    else if (w_storeCommit) r_storeCount <= r_storeCount + 32'd1;
  end

`ifdef DM_TRACE_EN
  // Store trace: one line per committed or faulting store.
  always @(posedge clk) begin
    if (!reset && w_isStore) begin
      if (w_fault)
        $display("%d@%h: store fault %h", $time, Pc4_MEM - 32'd4, ALUout_MEM);
      else
        $display("%d@%h: *%h <= %h", $time, Pc4_MEM - 32'd4,
                 {ALUout_MEM[31:2], 2'b00}, w_mergedWord);
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_dm.sv
// tb_mem_stage_dm: directed-vector bench for mem_stage_dm. Each stimulus
// cycle pushes its hand-computed expected outputs into a queue; a monitor
// pops one entry per cycle and compares all outputs.
module tb_mem_stage_dm;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef struct {
    int          id;
    logic [31:0] rd;
    logic        lv;
    logic [4:0]  wr;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] Instr_MEM;
  logic [31:0] Pc4_MEM;
  logic [31:0] ALUout_MEM;
  logic [31:0] WriteData_MEM;
  logic [4:0]  WriteReg_MEM;
  logic [31:0] ReadData_MEM;
  logic        LoadValid_MEM;
  logic [4:0]  WriteReg_out;
  logic        AddrErr;
  logic [31:0] StoreCount;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   rowId  = 0;

  mem_stage_dm dut (
    .clk           (clk),
    .reset         (reset),
    .Instr_MEM     (Instr_MEM),
    .Pc4_MEM       (Pc4_MEM),
    .ALUout_MEM    (ALUout_MEM),
    .WriteData_MEM (WriteData_MEM),
    .WriteReg_MEM  (WriteReg_MEM),
    .ReadData_MEM  (ReadData_MEM),
    .LoadValid_MEM (LoadValid_MEM),
    .WriteReg_out  (WriteReg_out),
    .AddrErr       (AddrErr),
    .StoreCount    (StoreCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected during that cycle.
  task automatic applyStimulus(input logic rst, input logic [5:0] op,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] wreg, input logic [31:0] expRd,
                               input logic expLv, input logic [4:0] expWr,
                               input logic expErr, input logic [31:0] expCnt);
    exp_t e;
    @(posedge clk);
    #1;
    rowId++;
    reset         = rst;
    Instr_MEM     = (op == OP_NOP) ? 32'h0 : {op, 5'd3, 5'd4, 16'h0};
    Pc4_MEM       = 32'h0040_0000 + 32'(rowId * 4);
    ALUout_MEM    = addr;
    WriteData_MEM = data;
    WriteReg_MEM  = wreg;
    e.id  = rowId;
    e.rd  = expRd;
    e.lv  = expLv;
    e.wr  = expWr;
    e.err = expErr;
    e.cnt = expCnt;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input int id, input string what,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL row%0d.%s got %h expected %h", id, what, actual, expected);
    end
  endtask

  // Monitor: on each falling edge, compare the DUT against the oldest
  // queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.id, "ReadData",   ReadData_MEM,           e.rd);
        checkOutput(e.id, "LoadValid",  {31'h0, LoadValid_MEM}, {31'h0, e.lv});
        checkOutput(e.id, "WriteReg",   {27'h0, WriteReg_out},  {27'h0, e.wr});
        checkOutput(e.id, "AddrErr",    {31'h0, AddrErr},       {31'h0, e.err});
        checkOutput(e.id, "StoreCount", StoreCount,             e.cnt);
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1; Instr_MEM = 32'h0; Pc4_MEM = 32'h0; ALUout_MEM = 32'h0;
    WriteData_MEM = 32'h0; WriteReg_MEM = 5'd0;
    repeat (2) @(posedge clk);
    $display("[TB] reset released, starting directed vectors");

    //            rst  op      addr          data          wreg  expRd         lv    wr    err   cnt
    applyStimulus(1'b0, OP_NOP, 32'h0,        32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, OP_SW,  32'h10,       32'h1234_5678,5'd5, 32'h0,        1'b0, 5'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, OP_LW,  32'h10,       32'h0,        5'd7, 32'h1234_5678,1'b1, 5'd7, 1'b0, 32'd1);
    applyStimulus(1'b0, OP_SB,  32'h11,       32'h0000_00FF,5'd6, 32'h0,        1'b0, 5'd0, 1'b0, 32'd1);
    applyStimulus(1'b0, OP_LW,  32'h10,       32'h0,        5'd8, 32'h1234_FF78,1'b1, 5'd8, 1'b0, 32'd2);
    applyStimulus(1'b0, OP_LB,  32'h11,       32'h0,        5'd9, 32'hFFFF_FFFF,1'b1, 5'd9, 1'b0, 32'd2);
    applyStimulus(1'b0, OP_LBU, 32'h11,       32'h0,        5'd10,32'h0000_00FF,1'b1, 5'd10,1'b0, 32'd2);
    applyStimulus(1'b0, OP_LB,  32'h10,       32'h0,        5'd11,32'h0000_0078,1'b1, 5'd11,1'b0, 32'd2);
    applyStimulus(1'b0, OP_SH,  32'h12,       32'h0000_8001,5'd6, 32'h0,        1'b0, 5'd0, 1'b0, 32'd2);
    applyStimulus(1'b0, OP_LW,  32'h10,       32'h0,        5'd12,32'h8001_FF78,1'b1, 5'd12,1'b0, 32'd3);
    applyStimulus(1'b0, OP_LH,  32'h12,       32'h0,        5'd13,32'hFFFF_8001,1'b1, 5'd13,1'b0, 32'd3);
    applyStimulus(1'b0, OP_LHU, 32'h12,       32'h0,        5'd14,32'h0000_8001,1'b1, 5'd14,1'b0, 32'd3);
    applyStimulus(1'b0, OP_LH,  32'h10,       32'h0,        5'd15,32'hFFFF_FF78,1'b1, 5'd15,1'b0, 32'd3);
    applyStimulus(1'b0, OP_LB,  32'h13,       32'h0,        5'd16,32'hFFFF_FF80,1'b1, 5'd16,1'b0, 32'd3);
    applyStimulus(1'b0, OP_LW,  32'h13,       32'h0,        5'd17,32'h0,        1'b0, 5'd0, 1'b0, 32'd3);
    applyStimulus(1'b0, OP_NOP, 32'h0,        32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 32'd3);
    applyStimulus(1'b0, OP_SW,  32'h3000,     32'hAAAA_AAAA,5'd1, 32'h0,        1'b0, 5'd0, 1'b1, 32'd3);
    applyStimulus(1'b0, OP_LW,  32'h0,        32'h0,        5'd2, 32'h0,        1'b1, 5'd2, 1'b1, 32'd3);
    applyStimulus(1'b0, OP_SW,  32'h2FFC,     32'hCAFE_F00D,5'd1, 32'h0,        1'b0, 5'd0, 1'b1, 32'd3);
    applyStimulus(1'b0, OP_LW,  32'h2FFC,     32'h0,        5'd18,32'hCAFE_F00D,1'b1, 5'd18,1'b1, 32'd4);
    applyStimulus(1'b0, OP_LW,  32'h3000,     32'h0,        5'd19,32'h0,        1'b0, 5'd0, 1'b1, 32'd4);
    applyStimulus(1'b0, OP_LW,  32'h1_0010,   32'h0,        5'd20,32'h0,        1'b0, 5'd0, 1'b1, 32'd4);
    applyStimulus(1'b1, OP_SW,  32'h20,       32'hDEAD_BEEF,5'd1, 32'h0,        1'b0, 5'd0, 1'b1, 32'd4);
    applyStimulus(1'b0, OP_LW,  32'h20,       32'h0,        5'd21,32'h0,        1'b1, 5'd21,1'b0, 32'd0);
    applyStimulus(1'b0, OP_LW,  32'h10,       32'h0,        5'd22,32'h0,        1'b1, 5'd22,1'b0, 32'd0);
    applyStimulus(1'b0, OP_LW,  32'h2FFC,     32'h0,        5'd23,32'h0,        1'b1, 5'd23,1'b0, 32'd0);
    applyStimulus(1'b0, OP_SH,  32'h13,       32'h0000_1234,5'd1, 32'h0,        1'b0, 5'd0, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, OP_NOP, 32'h10,     32'h5555_5555,5'd9, 32'h0,        1'b0, 5'd0, 1'b1, 32'd0);
    applyStimulus(1'b0, OP_LHU, 32'h12,       32'h0,        5'd24,32'h0,        1'b1, 5'd24,1'b1, 32'd0);

    guard = 0;
    while (expQ.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_dm.md
Name: mem_stage_dm

Overview:
- Memory-stage data memory and load/store unit of the 5-stage MIPS pipeline.
- Consumes the EX/MEM pipeline register outputs: instruction, PC+4, ALU result as address, store data and destination register.
- Performs aligned word/half/byte stores on the clock edge and returns sign- or zero-extended load data combinationally to the MEM/WB register.
- Detects misaligned or out-of-range accesses, and counts committed stores.

Parameters:
- DM_WORDS, 3072, number of 32-bit words (12 KiB, byte addresses 0x0000_0000-0x0000_2FFF).
- ADDR_W, 12, word-index width (ceil(log2(DM_WORDS))).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- Instr_MEM  input  32  instruction in MEM stage; opcode [31:26] selects operation.
- Pc4_MEM  input  32  PC+4 of instruction in MEM stage; used for store trace, PC = Pc4_MEM-4.
- ALUout_MEM  input  32  effective byte address.
- WriteData_MEM  input  32  store data (rt value, already forwarded).
- WriteReg_MEM  input  5  destination register; passed through for load forwarding.
- ReadData_MEM  output  32  extended load result; 0 for non-load or faulting load.
- LoadValid_MEM  output  1  high when Instr_MEM is a non-faulting load.
- WriteReg_out  output  5  equals WriteReg_MEM when LoadValid_MEM, else 0.
- AddrErr  output  1  registered sticky error flag.
- StoreCount  output  32  registered count of committed stores.

Behaviour:
- Decode, opcode only:
  - Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - Stores: sw 101011, sh 101001, sb 101000.
  - All other opcodes: no memory access.
- Word index = ALUout_MEM[ADDR_W+1:2]; byte offset = ALUout_MEM[1:0].
- Fault conditions:
  - Word access with offset != 0.
  - Half access with offset[0] != 0.
  - Address >= DM_WORDS*4.
- Stores, written at posedge clk when no fault:
  - sw writes the full word.
  - sh writes WriteData_MEM[15:0] into half offset[1].
  - sb writes WriteData_MEM[7:0] into byte lane offset.
  - Other lanes are unchanged.
- Faulting stores write nothing.
- Loads, combinational from the current array contents, zero latency:
  - lh and lb sign-extend; lhu and lbu zero-extend.
  - Faulting load: ReadData_MEM = 0 and LoadValid_MEM = 0.
- Read-after-write, same address:
  - A load in cycle N+1 sees the store committed at the edge ending cycle N.
  - There is no bypass within one cycle (one instruction per stage).
- AddrErr:
  - Set at posedge when any load or store faults.
  - Stays set until reset.
- StoreCount:
  - Increments by 1 at each posedge on which a non-faulting store commits.
  - Wraps 0xFFFF_FFFF -> 0.
- Reset, synchronous at posedge while reset = 1:
  - Every memory word = 0, AddrErr = 0, StoreCount = 0.
  - Any store presented in the same cycle is discarded.
  - Combinational outputs reflect the inputs against the cleared array from the next cycle.
- Reset asserted mid-stream: the pipeline register upstream also clears, so Instr_MEM = 0 (an sll no-op), meaning no access and no fault.
- Address bits above the range check are not aliased; out-of-range is a fault, not a wrap.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: on every committed store, $display("%d@%h: *%h <= %h", $time, Pc4_MEM-4, {ALUout_MEM[31:2],2'b00}, merged_word).
  - merged_word is the full 32-bit word after the lane merge.
  - Faulting stores print "%d@%h: store fault %h".
- Not defined: no display statements are compiled; functional behaviour is identical.

Test Plan:
- Reset, then sw with addr 0x0000_0010, data 0x1234_5678 -> next cycle lw 0x10 gives ReadData_MEM = 0x1234_5678, LoadValid_MEM = 1, StoreCount = 1.
- After the above:
  - sb addr 0x11, data 0xFF gives word 0x1234_FF78.
  - lb 0x11 -> 0xFFFF_FFFF; lbu 0x11 -> 0x0000_00FF.
- sh addr 0x12, data 0x0000_8001 gives word 0x8001_FF78:
  - lh 0x12 -> 0xFFFF_8001; lhu 0x12 -> 0x0000_8001.
- Faults:
  - lw 0x13 -> ReadData_MEM = 0, LoadValid_MEM = 0, AddrErr = 1 after the edge.
  - sw 0x3000 -> memory unchanged, StoreCount unchanged.
- Assert reset for one cycle while sw 0x20 = 0xDEAD_BEEF is presented -> lw 0x20 and lw 0x10 afterwards both read 0; AddrErr = 0, StoreCount = 0.
- Non-memory instruction (Instr_MEM = 0x0000_0000) for 10 cycles -> ReadData_MEM = 0, WriteReg_out = 0, no StoreCount change, no trace output with DM_TRACE_EN defined.
